frame_sync_rx: RTL and testbench



---
 rtl/frame_pkg.sv | 27 ++
 rtl/fas_detector.sv | 24 ++
 rtl/frame_sync_rx.sv | 183 ++++++++++++++++++
 tb/tb_frame_sync_rx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared frame geometry, FAS bytes and sync state encoding for the rx and tx frame paths.
package frame_pkg;
    typedef logic [1:0]  row_t;
    typedef logic [10:0] col_t;

    localparam int   NUM_ROWS          = 4;
    localparam int   NUM_COLS          = 1041;
    localparam row_t LAST_ROW          = row_t'(NUM_ROWS - 1);
    localparam col_t LAST_COL          = col_t'(NUM_COLS - 1);
    localparam col_t OH_LAST_COL       = 11'd15;
    localparam col_t PAYLOAD_FIRST_COL = OH_LAST_COL + 11'd1;
    localparam col_t FAS_LEN           = 11'd6;

    localparam logic [7:0]  FAS_A       = 8'hF6;
    localparam logic [7:0]  FAS_B       = 8'h28;
    localparam logic [47:0] FAS_PATTERN = {FAS_A, FAS_A, FAS_A, FAS_B, FAS_B, FAS_B};

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PRESYNC = 2'd1,
        SYNC    = 2'd2
    } sync_state_e;

    function automatic logic [7:0] fas_byte(input col_t col);
        return (col < 11'd3) ? FAS_A : FAS_B;
    endfunction
endpackage

// File: rtl/fas_detector.sv
// Six-byte sliding FAS matcher; match flag is combinational on the byte being shifted in.
// Cleared whenever the receiver is not hunting so every hunt starts from an empty window.
module fas_detector
    import frame_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic [7:0] i_data,
    output logic       o_match
);
    logic [39:0] sr_q;

    assign o_match = i_en && ({sr_q, i_data} == FAS_PATTERN);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            sr_q <= '0;
        end else if (i_en) begin
            sr_q <= {sr_q[31:0], i_data};
        end
    end
endmodule

// File: rtl/frame_sync_rx.sv
// Rx frame synchronizer: FAS hunt/presync/sync, row/col tracking, per-row BIP-8 retransmit request.
// Latency 1 cycle; no backpressure, i_valid=0 cycles hold state. FRAME_SYNC_RX_ERR_CNT_EN adds o_bip_err_cnt.
module frame_sync_rx
    import frame_pkg::*;
#(
    parameter int MISS_LIMIT     = 4,
    parameter int CONFIRM_FRAMES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [7:0]  i_data,
    output logic        o_valid,
    output logic [7:0]  o_data,
    output logic [1:0]  o_row_cnt,
    output logic [10:0] o_col_cnt,
    output logic        o_sof,
    output logic        o_locked,
`ifdef FRAME_SYNC_RX_ERR_CNT_EN
    output logic [15:0] o_bip_err_cnt,
`endif
    output logic        o_line_retrans_req
);
    localparam logic [3:0] MISS_TGT    = 4'(MISS_LIMIT);
    localparam logic [2:0] CONFIRM_TGT = 3'(CONFIRM_FRAMES);

    sync_state_e state_q, state_d;
    row_t        row_q, row_d;
    col_t        col_q, col_d;
    logic [7:0]  bip_q, bip_d;
    logic        fas_ok_q, fas_ok_d;
    logic [3:0]  miss_q, miss_d;
    logic [2:0]  confirm_q, confirm_d;
    logic        req_d;
    logic        fas_match;
    logic        fas_cur;

    logic        o_valid_q, o_sof_q, o_locked_q, o_req_q;
    logic [7:0]  o_data_q;
    row_t        o_row_q;
    col_t        o_col_q;

    fas_detector u_fas (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (state_q != HUNT),
        .i_en    (i_valid && (state_q == HUNT)),
        .i_data  (i_data),
        .o_match (fas_match)
    );

    // Running AND of the FAS columns seen so far in row 0 of this frame.
    assign fas_cur = ((col_q == '0) || fas_ok_q) && (i_data == fas_byte(col_q));

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        bip_d     = bip_q;
        fas_ok_d  = fas_ok_q;
        miss_d    = miss_q;
        confirm_d = confirm_q;
        req_d     = 1'b0;
        if (i_valid) begin
            if (state_q == HUNT) begin
                if (fas_match) begin
                    state_d   = PRESYNC;
                    row_d     = '0;
                    col_d     = FAS_LEN;
                    confirm_d = '0;
                end
            end else begin
                if (col_q == LAST_COL) begin
                    col_d = '0;
                    row_d = (row_q == LAST_ROW) ? '0 : row_q + 2'd1;
                end else begin
                    col_d = col_q + 11'd1;
                end

                if (col_q == OH_LAST_COL) begin
                    bip_d = '0;
                end else if (col_q >= PAYLOAD_FIRST_COL && col_q < LAST_COL) begin
                    bip_d = bip_q ^ i_data;
                end else if (col_q == LAST_COL) begin
                    req_d = (state_q == SYNC) && (i_data != bip_q);
                end

                if (row_q == '0 && col_q < FAS_LEN) begin
                    fas_ok_d = fas_cur;
                    if (col_q == FAS_LEN - 11'd1) begin
                        if (state_q == PRESYNC) begin
                            if (fas_cur) begin
                                confirm_d = confirm_q + 3'd1;
                                if (confirm_d == CONFIRM_TGT) begin
                                    state_d = SYNC;
                                    miss_d  = '0;
                                end
                            end else begin
                                state_d = HUNT;
                            end
                        end else if (fas_cur) begin
                            miss_d = '0;
                        end else begin
                            miss_d = miss_q + 4'd1;
                            if (miss_d == MISS_TGT) begin
                                state_d = HUNT;
                            end
                        end
                    end
                end
            end

            if (state_d == HUNT && state_q != HUNT) begin
                row_d     = '0;
                col_d     = '0;
                bip_d     = '0;
                miss_d    = '0;
                confirm_d = '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= HUNT;
            row_q      <= '0;
            col_q      <= '0;
            bip_q      <= '0;
            fas_ok_q   <= 1'b0;
            miss_q     <= '0;
            confirm_q  <= '0;
            o_valid_q  <= 1'b0;
            o_data_q   <= '0;
            o_row_q    <= '0;
            o_col_q    <= '0;
            o_sof_q    <= 1'b0;
            o_locked_q <= 1'b0;
            o_req_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            bip_q      <= bip_d;
            fas_ok_q   <= fas_ok_d;
            miss_q     <= miss_d;
            confirm_q  <= confirm_d;
            o_valid_q  <= i_valid;
            o_sof_q    <= i_valid && (state_q != HUNT) && (row_q == '0) && (col_q == '0);
            o_locked_q <= (state_q == SYNC);
            o_req_q    <= req_d;
            if (i_valid) begin
                o_data_q <= i_data;
                o_row_q  <= row_q;
                o_col_q  <= col_q;
            end
        end
    end

`ifdef FRAME_SYNC_RX_ERR_CNT_EN
    logic [15:0] err_cnt_q;
    logic        drop_sync;

    assign drop_sync = (state_q == SYNC) && (state_d == HUNT);

    always_ff @(posedge i_clk) begin
        if (i_rst || drop_sync) begin
            err_cnt_q <= '0;
        end else if (req_d && err_cnt_q != 16'hFFFF) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign o_bip_err_cnt = err_cnt_q;
`endif

    assign o_valid            = o_valid_q;
    assign o_data             = o_data_q;
    assign o_row_cnt          = o_row_q;
    assign o_col_cnt          = o_col_q;
    assign o_sof              = o_sof_q;
    assign o_locked           = o_locked_q;
    assign o_line_retrans_req = o_req_q;
endmodule

// File: tb/tb_frame_sync_rx.sv
// Scoreboard bench for frame_sync_rx: directed frame stream with hand-placed alignment events.
module tb_frame_sync_rx;
    localparam int F  = 4164;   // bytes per frame
    localparam int NC = 1041;
    localparam int B  = 37;     // offset of the first true FAS

    localparam int S_HUNT = 0, S_PRE = 1, S_SYNC = 2;

    logic        clk = 1'b0;
    logic        rst, vld;
    logic [7:0]  din;
    logic        o_valid, o_sof, o_locked, o_req;
    logic [7:0]  o_data;
    logic [1:0]  o_row;
    logic [10:0] o_col;
`ifdef FRAME_SYNC_RX_ERR_CNT_EN
    logic [15:0] o_err_cnt;
`endif

    always #5 clk = ~clk;

    frame_sync_rx dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_valid            (vld),
        .i_data             (din),
        .o_valid            (o_valid),
        .o_data             (o_data),
        .o_row_cnt          (o_row),
        .o_col_cnt          (o_col),
        .o_sof              (o_sof),
        .o_locked           (o_locked),
`ifdef FRAME_SYNC_RX_ERR_CNT_EN
        .o_bip_err_cnt      (o_err_cnt),
`endif
        .o_line_retrans_req (o_req)
    );

    typedef struct packed {
        logic [7:0]  d;
        logic [1:0]  r;
        logic [10:0] c;
        logic        sof;
        logic        lk;
        logic        req;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   gi       = 0;
    int   st       = S_HUNT;
    int   base     = B;
    bit   gaps     = 1'b0;
    bit   mon_en   = 1'b0;
    int   req_seen = 0;

    function automatic logic [7:0] payload(input int f, input int r, input int c);
        return 8'(f * 7 + r * 13 + c);
    endfunction

    function automatic logic [7:0] bip_of(input int f, input int r);
        logic [7:0] b = 8'h00;
        for (int c = 16; c < 1040; c++) b ^= payload(f, r, c);
        return b;
    endfunction

    function automatic bit corrupt_row(input int f, input int r);
        return (f == 4 && r == 2) || (f == 12 && r == 1);
    endfunction

    // Line stream: junk prefix, then frames; frames 5-8 carry a bad FAS,
    // frame 8 row 1 hides a FAS lookalike in its payload.
    function automatic logic [7:0] gen(input int g);
        int lin, f, r, c;
        if (g < B) return 8'(g);
        lin = g - B;
        f   = lin / F;
        r   = (lin % F) / NC;
        c   = lin % NC;
        if (r == 0 && c < 6) begin
            if (f >= 5 && f <= 8 && c == 0) return 8'h00;
            return (c < 3) ? 8'hF6 : 8'h28;
        end
        if (c < 16) return 8'h00;
        if (c == 1040) return bip_of(f, r);
        if (f == 8 && r == 1 && c >= 100 && c <= 105) return (c < 103) ? 8'hF6 : 8'h28;
        if (corrupt_row(f, r) && c == 500) return payload(f, r, c) ^ 8'h01;
        return payload(f, r, c);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic send_one();
        exp_t x;
        int lin, r, c, tl;
        if (gaps) begin
            while ($urandom_range(0, 1) == 0) begin
                vld = 1'b0;
                din = 8'($urandom);
                @(posedge clk);
                #1;
            end
        end
        vld = 1'b1;
        din = gen(gi);
        r = 0;
        c = 0;
        if (st != S_HUNT) begin
            lin = (((gi - base) % F) + F) % F;
            r   = lin / NC;
            c   = lin % NC;
        end
        tl    = gi - B;
        x.d   = din;
        x.r   = 2'(r);
        x.c   = 11'(c);
        x.sof = (st != S_HUNT) && r == 0 && c == 0;
        x.lk  = (st == S_SYNC);
        x.req = (st == S_SYNC) && tl >= 0 && (tl % NC) == 1040 && corrupt_row(tl / F, (tl % F) / NC);
        q.push_back(x);
        gi++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(input int n);
        while (gi < n) send_one();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"},  32'(o_valid),  32'h0);
        chk({tag, "_data"},   32'(o_data),   32'h0);
        chk({tag, "_row"},    32'(o_row),    32'h0);
        chk({tag, "_col"},    32'(o_col),    32'h0);
        chk({tag, "_sof"},    32'(o_sof),    32'h0);
        chk({tag, "_locked"}, 32'(o_locked), 32'h0);
        chk({tag, "_req"},    32'(o_req),    32'h0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (o_req) req_seen++;
            n_tests++;
            if (o_valid) begin
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: got data %02h with nothing expected", o_data);
                end else begin
                    e = q.pop_front();
                    if ({o_data, o_row, o_col, o_sof, o_locked, o_req} !== e) begin
                        n_fail++;
                        $display("FAIL byte: got d=%02h r=%0d c=%0d sof=%0b lk=%0b req=%0b expected d=%02h r=%0d c=%0d sof=%0b lk=%0b req=%0b",
                                 o_data, o_row, o_col, o_sof, o_locked, o_req,
                                 e.d, e.r, e.c, e.sof, e.lk, e.req);
                    end
                end
            end else if (o_req !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_req: got %0b expected 0", o_req);
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        rst = 1'b1;
        vld = 1'b0;
        din = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Acquire on the true FAS at offset 37, lock one frame later.
        st = S_HUNT;                 run_until(B + 6);
        st = S_PRE;   base = B;      run_until(B + F + 6);
        st = S_SYNC;                 run_until(B + 3 * F);
        gaps = 1'b1;                 run_until(B + 4 * F);
        gaps = 1'b0;
        // Frame 4 row 2 BIP error, frames 5-7 missed FAS, frame 8 fourth miss.
        run_until(B + 8 * F + 6);
        st = S_HUNT;                 run_until(B + 8 * F + NC + 106);
        // False lock on the payload lookalike, rejected one frame later.
        st = S_PRE;   base = B + 8 * F + NC + 100;
        run_until(base + F + 6);
        st = S_HUNT;                 run_until(B + 10 * F + 6);
        st = S_PRE;   base = B;      run_until(B + 11 * F + 6);
        st = S_SYNC;                 run_until(B + 12 * F + NC + 700);

        // Reset at row 1 col 700 with a corrupted row pending.
        rst = 1'b1;
        vld = 1'b1;
        din = gen(gi);
        gi++;
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("midreset");
        rst = 1'b0;
        vld = 1'b0;
        @(posedge clk);
        #1;
        st = S_HUNT;                 run_until(B + 13 * F);
        vld = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        chk("retrans_pulses", 32'(req_seen), 32'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
